// File: rtl/uart_rx_typed_chunker.sv
// uart_rx_typed_chunker
//   Consumes the byte stream from uart_rx, locates typed chunks framed by the
//   0x00 escape protocol, unescapes their payload into a working buffer and
//   publishes each complete chunk with its type and byte count.
//
//   Wire protocol: 00 00 = literal 0x00, 00 01 = end of chunk,
//   00 T (T >= 02) = start of chunk of type T, anything else = literal.
//
// Ports
//   CLK, RST           clock, synchronous active-high reset
//   rx_ready, rx_data  one-cycle byte strobe and received byte
//   is_chunk_ready     one-cycle pulse, a chunk was published
//   chunk_type         type of the last published chunk
//   chunk_byte_size    payload length of the last published chunk
//   chunk_bytes        payload, byte i at [8i+7:8i], unused bytes are 0
//   is_overflow        one-cycle pulse, an oversized chunk was dropped
//   is_protocol_error  one-cycle pulse, illegal escape or abandoned chunk
module uart_rx_typed_chunker #(
    parameter int BUFFER_BYTE_SIZE  = 5,
    parameter int BUFFER_INDEX_SIZE = 32
) (
    input  logic                          CLK,
    input  logic                          RST,
    input  logic                          rx_ready,
    input  logic [7:0]                    rx_data,
    output logic                          is_chunk_ready,
    output logic [7:0]                    chunk_type,
    output logic [BUFFER_INDEX_SIZE-1:0]  chunk_byte_size,
    output logic [BUFFER_BYTE_SIZE*8-1:0] chunk_bytes,
    output logic                          is_overflow,
    output logic                          is_protocol_error
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IDLE_ESC,
        S_DATA,
        S_DATA_ESC,
        S_DISCARD,
        S_DISCARD_ESC
    } state_e;

    state_e                        state_q, state_d;
    logic [7:0]                    type_q, type_d;
    logic [BUFFER_INDEX_SIZE-1:0]  cnt_q, cnt_d;
    logic [BUFFER_BYTE_SIZE*8-1:0] buf_q, buf_d;

    // Published (double-buffered) outputs
    logic [7:0]                    out_type_q, out_type_d;
    logic [BUFFER_INDEX_SIZE-1:0]  out_size_q, out_size_d;
    logic [BUFFER_BYTE_SIZE*8-1:0] out_bytes_q, out_bytes_d;
    logic                          rdy_q, rdy_d;
    logic                          ovf_q, ovf_d;
    logic                          err_q, err_d;

    // Shared actions requested by the state decode below
    logic start;
    logic store;

    always_comb begin
        state_d     = state_q;
        type_d      = type_q;
        cnt_d       = cnt_q;
        buf_d       = buf_q;
        out_type_d  = out_type_q;
        out_size_d  = out_size_q;
        out_bytes_d = out_bytes_q;
        rdy_d       = 1'b0;
        ovf_d       = 1'b0;
        err_d       = 1'b0;
        start       = 1'b0;
        store       = 1'b0;

        if (rx_ready) begin
            case (state_q)
                S_IDLE: begin
                    if (rx_data == 8'h00) state_d = S_IDLE_ESC;
                end
                S_IDLE_ESC: begin
                    if (rx_data >= 8'h02) begin
                        start = 1'b1;
                    end else begin
                        err_d   = 1'b1;
                        state_d = S_IDLE;
                    end
                end
                S_DATA: begin
                    if (rx_data != 8'h00) store = 1'b1;
                    else                  state_d = S_DATA_ESC;
                end
                S_DATA_ESC: begin
                    if (rx_data == 8'h00) begin
                        store = 1'b1;
                    end else if (rx_data == 8'h01) begin
                        out_type_d  = type_q;
                        out_size_d  = cnt_q;
                        out_bytes_d = buf_q;
                        rdy_d       = 1'b1;
                        state_d     = S_IDLE;
                    end else begin
                        err_d = 1'b1;
                        start = 1'b1;
                    end
                end
                S_DISCARD: begin
                    if (rx_data == 8'h00) state_d = S_DISCARD_ESC;
                end
                S_DISCARD_ESC: begin
                    if (rx_data == 8'h00) begin
                        state_d = S_DISCARD;
                    end else if (rx_data == 8'h01) begin
                        ovf_d   = 1'b1;
                        state_d = S_IDLE;
                    end else begin
                        ovf_d = 1'b1;
                        start = 1'b1;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end

        // Starting a chunk clears the working buffer so bytes beyond the
        // final count publish as zero.
        if (start) begin
            type_d  = rx_data;
            cnt_d   = '0;
            buf_d   = '0;
            state_d = S_DATA;
        end

        // A store into a full buffer diverts into DISCARD instead of writing.
        if (store) begin
            if (cnt_q < BUFFER_INDEX_SIZE'(BUFFER_BYTE_SIZE)) begin
                for (int unsigned i = 0; i < BUFFER_BYTE_SIZE; i++) begin
                    if (cnt_q == BUFFER_INDEX_SIZE'(i)) buf_d[8*i +: 8] = rx_data;
                end
                cnt_d   = cnt_q + BUFFER_INDEX_SIZE'(1);
                state_d = S_DATA;
            end else begin
                state_d = S_DISCARD;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q     <= S_IDLE;
            type_q      <= '0;
            cnt_q       <= '0;
            buf_q       <= '0;
            out_type_q  <= '0;
            out_size_q  <= '0;
            out_bytes_q <= '0;
            rdy_q       <= 1'b0;
            ovf_q       <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            type_q      <= type_d;
            cnt_q       <= cnt_d;
            buf_q       <= buf_d;
            out_type_q  <= out_type_d;
            out_size_q  <= out_size_d;
            out_bytes_q <= out_bytes_d;
            rdy_q       <= rdy_d;
            ovf_q       <= ovf_d;
            err_q       <= err_d;
        end
    end

    assign is_chunk_ready    = rdy_q;
    assign is_overflow       = ovf_q;
    assign is_protocol_error = err_q;
    assign chunk_type        = out_type_q;
    assign chunk_byte_size   = out_size_q;
    assign chunk_bytes       = out_bytes_q;

endmodule

// File: tb/tb_uart_rx_typed_chunker.sv
// Testbench for uart_rx_typed_chunker (BUFFER_BYTE_SIZE = 5).
// Table rows hold a byte sequence plus the event each byte is expected to
// trigger; the driver pushes expected events into a queue, the monitor pops
// and compares them whenever a pulse appears.
module tb_uart_rx_typed_chunker;

    localparam int BBS = 5;
    localparam int BIS = 32;

    localparam logic [1:0] EV_NONE  = 2'd0;
    localparam logic [1:0] EV_CHUNK = 2'd1;
    localparam logic [1:0] EV_OVF   = 2'd2;
    localparam logic [1:0] EV_ERR   = 2'd3;

    logic             CLK = 1'b0;
    logic             RST;
    logic             rx_ready;
    logic [7:0]       rx_data;
    logic             is_chunk_ready;
    logic [7:0]       chunk_type;
    logic [BIS-1:0]   chunk_byte_size;
    logic [BBS*8-1:0] chunk_bytes;
    logic             is_overflow;
    logic             is_protocol_error;

    uart_rx_typed_chunker #(
        .BUFFER_BYTE_SIZE (BBS),
        .BUFFER_INDEX_SIZE(BIS)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .rx_ready         (rx_ready),
        .rx_data          (rx_data),
        .is_chunk_ready   (is_chunk_ready),
        .chunk_type       (chunk_type),
        .chunk_byte_size  (chunk_byte_size),
        .chunk_bytes      (chunk_bytes),
        .is_overflow      (is_overflow),
        .is_protocol_error(is_protocol_error)
    );

    always #5 CLK = ~CLK;

    int unsigned cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct packed {
        logic [1:0]  kind;
        logic [7:0]  ty;
        logic [31:0] sz;
        logic [39:0] by;
        logic [31:0] due;
    } exp_t;

    typedef struct packed {
        logic [7:0]        len;
        logic [15:0][7:0]  b;
        logic [15:0][1:0]  ev;
        logic              gap;
        logic [7:0]        ty;
        logic [31:0]       sz;
        logic [39:0]       by;
    } vec_t;

    localparam int NV = 9;
    vec_t tbl[NV];
    exp_t q[$];

    int tests = 0;
    int fails = 0;

    // Bench's own record of what the published outputs should hold
    logic [7:0]  pub_ty;
    logic [31:0] pub_sz;
    logic [39:0] pub_by;

    // Bytes given MSB-first in wire order
    function automatic vec_t mk(input int n, input logic [127:0] s, input logic gap,
                                input logic [7:0] ty, input logic [31:0] sz,
                                input logic [39:0] by);
        vec_t v;
        v     = '0;
        v.len = 8'(n);
        for (int i = 0; i < n; i++) v.b[i] = s[8*(n-1-i) +: 8];
        v.gap = gap;
        v.ty  = ty;
        v.sz  = sz;
        v.by  = by;
        return v;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every pulse must match the oldest expected event
    exp_t        m_e;
    logic [1:0]  m_kind;
    always @(negedge CLK) begin
        if (is_chunk_ready || is_overflow || is_protocol_error) begin
            chk("pulse_onehot",
                64'(is_chunk_ready) + 64'(is_overflow) + 64'(is_protocol_error), 64'd1);
            m_kind = is_chunk_ready ? EV_CHUNK : (is_overflow ? EV_OVF : EV_ERR);
            if (q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_pulse: got kind %0d at cycle %0d expected none",
                         m_kind, cyc);
            end else begin
                m_e = q.pop_front();
                chk("pulse_kind",  64'(m_kind), 64'(m_e.kind));
                chk("pulse_cycle", 64'(cyc), 64'(m_e.due));
                chk("chunk_type",  64'(chunk_type), 64'(m_e.ty));
                chk("chunk_size",  64'(chunk_byte_size), 64'(m_e.sz));
                chk("chunk_bytes", 64'(chunk_bytes), 64'(m_e.by));
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_ready"}, 64'(is_chunk_ready), 64'd0);
        chk({tag, "_ovf"},   64'(is_overflow), 64'd0);
        chk({tag, "_err"},   64'(is_protocol_error), 64'd0);
        chk({tag, "_type"},  64'(chunk_type), 64'd0);
        chk({tag, "_size"},  64'(chunk_byte_size), 64'd0);
        chk({tag, "_bytes"}, 64'(chunk_bytes), 64'd0);
    endtask

    task automatic run_row(input vec_t v);
        exp_t e;
        for (int i = 0; i < int'(v.len); i++) begin
            @(negedge CLK);
            rx_ready = 1'b1;
            rx_data  = v.b[i];
            if (v.ev[i] != EV_NONE) begin
                if (v.ev[i] == EV_CHUNK) begin
                    pub_ty = v.ty;
                    pub_sz = v.sz;
                    pub_by = v.by;
                end
                e.kind = v.ev[i];
                e.ty   = pub_ty;
                e.sz   = pub_sz;
                e.by   = pub_by;
                e.due  = cyc + 1;
                q.push_back(e);
            end
            if (v.gap) begin
                @(negedge CLK);
                rx_ready = 1'b0;
                rx_data  = 8'($urandom);
            end
        end
        @(negedge CLK);
        rx_ready = 1'b0;
        rx_data  = 8'($urandom);
        repeat (2) @(negedge CLK);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        // Basic chunk; 0x01 inside data is literal, 00 00 is a literal zero
        tbl[0] = mk(10, 128'h00_02_01_02_03_00_00_03_00_01, 1'b1,
                    8'h02, 32'd5, 40'h03_00_03_02_01);
        tbl[0].ev[9] = EV_CHUNK;
        // Overflow on sixth byte, dropped; published outputs held
        tbl[1] = mk(10, 128'h00_02_11_12_13_14_15_16_00_01, 1'b0, 8'h0, 32'd0, 40'h0);
        tbl[1].ev[9] = EV_OVF;
        // Empty chunk
        tbl[2] = mk(4, 128'h00_07_00_01, 1'b0, 8'h07, 32'd0, 40'h0);
        tbl[2].ev[3] = EV_CHUNK;
        // Abandon and restart
        tbl[3] = mk(8, 128'h00_02_AA_00_05_BB_00_01, 1'b1, 8'h05, 32'd1, 40'h00_00_00_00_BB);
        tbl[3].ev[4] = EV_ERR;
        tbl[3].ev[7] = EV_CHUNK;
        // Junk then bad escape in IDLE
        tbl[4] = mk(4, 128'h41_42_00_01, 1'b0, 8'h0, 32'd0, 40'h0);
        tbl[4].ev[3] = EV_ERR;
        // 00 00 in IDLE is an error, then 00 01 in IDLE is another
        tbl[5] = mk(4, 128'h00_00_00_01, 1'b1, 8'h0, 32'd0, 40'h0);
        tbl[5].ev[1] = EV_ERR;
        tbl[5].ev[3] = EV_ERR;
        // Overflow triggered by an escaped zero on the sixth byte
        tbl[6] = mk(11, 128'h00_04_01_02_03_04_05_00_00_00_01, 1'b0, 8'h0, 32'd0, 40'h0);
        tbl[6].ev[10] = EV_OVF;
        // Discard with literal zero, then restart from DISCARD_ESC
        tbl[7] = mk(16, 128'h00_02_21_22_23_24_25_26_00_00_27_00_09_33_00_01, 1'b0,
                    8'h09, 32'd1, 40'h00_00_00_00_33);
        tbl[7].ev[12] = EV_OVF;
        tbl[7].ev[15] = EV_CHUNK;
        // Chunk after mid-chunk reset
        tbl[8] = mk(5, 128'h00_03_CC_00_01, 1'b1, 8'h03, 32'd1, 40'h00_00_00_00_CC);
        tbl[8].ev[4] = EV_CHUNK;

        pub_ty   = '0;
        pub_sz   = '0;
        pub_by   = '0;
        RST      = 1'b1;
        rx_ready = 1'b0;
        rx_data  = 8'h00;
        repeat (3) @(negedge CLK);
        check_reset_outputs("reset");
        RST = 1'b0;

        for (int r = 0; r < NV - 1; r++) run_row(tbl[r]);

        // Reset mid-chunk: partial chunk discarded, no pulse, outputs cleared
        begin
            vec_t part;
            part = mk(3, 128'h00_02_AA, 1'b0, 8'h0, 32'd0, 40'h0);
            for (int i = 0; i < 3; i++) begin
                @(negedge CLK);
                rx_ready = 1'b1;
                rx_data  = part.b[i];
            end
        end
        @(negedge CLK);
        rx_ready = 1'b0;
        RST      = 1'b1;
        @(negedge CLK);
        RST = 1'b0;
        check_reset_outputs("midreset");
        pub_ty = '0;
        pub_sz = '0;
        pub_by = '0;
        @(negedge CLK);
        check_reset_outputs("postreset");

        run_row(tbl[NV-1]);

        repeat (5) @(negedge CLK);
        tests++;
        if (q.size() != 0) begin
            fails++;
            $display("FAIL missing_pulses: got %0d events outstanding expected 0", q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_rx_typed_chunker.md
# uart_rx_typed_chunker

Receive-side counterpart of `uart_tx_typed_chunker`. It consumes the byte stream from `uart_rx`, finds typed chunks framed by the 0x00 escape protocol, unescapes their payload into a parametrised buffer, and publishes each complete chunk with its type and byte count. It sits between `uart_rx` and the application logic in `main`, and detects buffer overflow and framing errors.

## Interface
Parameters:
- BUFFER_BYTE_SIZE, 5: maximum payload bytes per chunk.
- BUFFER_INDEX_SIZE, 32: width of the byte counter and `chunk_byte_size`. It must be able to represent BUFFER_BYTE_SIZE + 1.

Ports:
- CLK  in  1  system clock.
- RST  in  1  synchronous, active-high reset.
- rx_ready  in  1  one-cycle strobe: `rx_data` holds a valid received byte.
- rx_data  in  8  received byte.
- is_chunk_ready  out  1  one-cycle pulse: a new chunk has been published.
- chunk_type  out  8  type of the last published chunk.
- chunk_byte_size  out  BUFFER_INDEX_SIZE  payload length of the last published chunk.
- chunk_bytes  out  BUFFER_BYTE_SIZE*8  payload. Byte i sits at [8i+7:8i]. Bytes at index ≥ size are 0.
- is_overflow  out  1  one-cycle pulse: a chunk was dropped because it exceeded the buffer.
- is_protocol_error  out  1  one-cycle pulse: an illegal escape was seen, or a chunk was abandoned.

## Operation
- Wire protocol:
  - 0x00 0x00 is a literal 0x00 payload byte.
  - 0x00 0x01 is end of chunk.
  - 0x00 T, with T ≥ 0x02, is the start of a chunk of type T.
  - Any other byte is literal payload.
- All state advances only on cycles where `rx_ready` = 1. Every other cycle holds state.
- States:
  - IDLE
    - 0x00 → IDLE_ESC.
    - Any other byte is ignored.
  - IDLE_ESC
    - T ≥ 0x02 → start chunk: working type = T, count = 0, working buffer cleared to 0. Next state DATA.
    - 0x00 or 0x01 → pulse `is_protocol_error`, next state IDLE.
  - DATA
    - Byte ≠ 0x00 → store it.
    - 0x00 → DATA_ESC.
  - DATA_ESC
    - 0x00 → store 0x00, next state DATA.
    - 0x01 → publish, next state IDLE.
    - T ≥ 0x02 → pulse `is_protocol_error` (abandon the current chunk), then start a new chunk of type T, next state DATA.
  - DISCARD
    - 0x00 → DISCARD_ESC.
    - Other bytes are dropped.
  - DISCARD_ESC
    - 0x00 → next state DISCARD.
    - 0x01 → pulse `is_overflow`, next state IDLE.
    - T ≥ 0x02 → pulse `is_overflow`, then start a new chunk of type T, next state DATA.
- Store operation:
  - If count < BUFFER_BYTE_SIZE: write the byte to working buffer[count], count += 1.
  - If count == BUFFER_BYTE_SIZE: next state DISCARD. Published outputs are untouched.
- Publish: copy working type, count and buffer to the output registers in one cycle, and pulse `is_chunk_ready`.
- Published outputs are double-buffered. They stay stable from one publish to the next, including while later chunks are being received or dropped.
- An empty chunk (0x00 T 0x00 0x01) publishes with size 0 and all bytes 0.
- Count arithmetic is unsigned and never wraps, because overflow is caught at BUFFER_BYTE_SIZE.

## Timing
- Reset:
  - All outputs 0, state IDLE, working buffer and count 0.
  - Reset mid-chunk discards the partial chunk and emits no pulse.
- `is_chunk_ready`, `is_overflow` and `is_protocol_error` assert for exactly one cycle. That cycle is the one after the `rx_ready` cycle carrying the deciding byte.
- `chunk_*` outputs are valid in the same cycle `is_chunk_ready` is high.
- At most one of the three pulses is high in any cycle.
- Throughput: accepts `rx_ready` on consecutive cycles. No back-pressure.
- `rx_data` is sampled only when `rx_ready` = 1.

## Test plan
All scenarios use BUFFER_BYTE_SIZE = 5.
- Basic chunk: bytes 00 02 01 02 03 00 00 03 00 01 → one `is_chunk_ready` pulse; type 0x02, size 5, `chunk_bytes` = 0x03_00_03_02_01.
- Empty chunk: 00 07 00 01 → `is_chunk_ready`; type 0x07, size 0, bytes 0.
- Overflow: after scenario 1, send 00 02 11 12 13 14 15 16 00 01 → `is_overflow` pulse on the 0x01 byte; no `is_chunk_ready`; outputs still hold scenario 1 values.
- Abandon and restart: 00 02 AA 00 05 BB 00 01 → `is_protocol_error` on the 0x05 byte, then `is_chunk_ready` with type 0x05, size 1, byte0 0xBB.
- Junk and bad escape in IDLE: 41 42 00 01 → 0x41 and 0x42 ignored; single `is_protocol_error` pulse; no chunk published.
- Reset mid-chunk: 00 02 AA, pulse RST for 1 cycle, then 00 03 CC 00 01 → after reset all outputs 0 with no pulse; then chunk type 0x03, size 1, byte0 0xCC.
